sensor_averager: RTL and testbench
==================================

Name: sensor_averager

Overview:
- Upstream stage of the baggage-height square-root block. Collects one frame of NUM_SENSORS 8-bit sensor readings over a valid/ready stream.
- Discards zero (faulty) readings and averages the rest with a sequential restoring divider.
- Presents the 8-bit average, with a valid/ready handshake, as the radicand for the square-root stage.

Parameters:
- NUM_SENSORS, 4, readings per frame (2..8).
- SUM_W, 8+$clog2(NUM_SENSORS), accumulator width (derived, not overridden).
- CNT_W, $clog2(NUM_SENSORS+1), width of the valid-reading counter (derived).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  sample_data holds a reading.
- sample_data  in  8  sensor reading; 0 means faulty/absent.
- sample_ready  out  1  block accepts a reading this cycle.
- avg_valid  out  1  avg_data holds a frame result.
- avg_data  out  8  frame average (feeds the square-root input).
- avg_ready  in  1  downstream consumes the result.
- frame_busy  out  1  high from the first accepted reading until the result is consumed.

Behaviour:
- Reset (async, rst_n=0): state=COLLECT; sum, nz_cnt and sample index = 0; sample_ready=1; avg_valid=0; avg_data=0; frame_busy=0. Any frame in progress is discarded.
- A reading is accepted on a clock edge where sample_valid && sample_ready.
- COLLECT:
  - sample_ready=1.
  - Each accepted reading increments idx.
  - A nonzero reading adds to sum (SUM_W bits, no overflow possible) and increments nz_cnt.
  - When the accepted reading has idx==NUM_SENSORS-1, go to DIVIDE next cycle.
- DIVIDE:
  - sample_ready=0.
  - If nz_cnt==0: avg_data=0 and go straight to OUTPUT, 1 cycle in DIVIDE.
  - Otherwise run the restoring divide, dividend=sum, divisor=nz_cnt. It takes exactly SUM_W cycles, one quotient bit per cycle, MSB first.
  - Then load the low 8 bits of the quotient into avg_data (the quotient is ≤255 by construction) and go to OUTPUT.
- OUTPUT:
  - avg_valid=1. avg_data is held stable while avg_valid=1 && avg_ready=0.
  - On avg_valid && avg_ready: clear avg_valid, sum, nz_cnt and idx, return to COLLECT. sample_ready rises the following cycle.
- Latency: last reading accepted at cycle T; avg_valid asserts at T+1+SUM_W (10+1 for N=4), or T+2 for an all-zero frame.
- No reading is accepted outside COLLECT. This backpressure is never dropped.
- avg_data retains its last value after handshake until the next frame result is loaded.
- The divide uses truncation (floor) unless ROUND_EN is defined.

Optional Feature:
- Macro: SENSOR_AVERAGER_ROUND_EN.
- Defined: dividend = sum + (nz_cnt>>1), giving round-half-up to nearest; the accumulator gets one extra bit and the divide takes SUM_W+1 cycles.
- Undefined: dividend = sum, giving floor division in SUM_W cycles.
- The all-zero frame result is 0 in both builds.

Decomposition:
- Shared package, so the square-root stage and the top-level agree on widths:
  - SENSOR_W=8.
  - Default NUM_SENSORS.
  - State encoding enum {COLLECT, DIVIDE, OUTPUT}.
- One natural sub-module: seq_divider.
  - Parameterised dividend and divisor widths.
  - Handshake: start/done.
  - Outputs: quotient and remainder.
- The sensor_averager FSM drives seq_divider's start and captures the quotient on done.

Test Plan:
- Readings 10,20,30,40, avg_ready=1 -> avg_data=25, avg_valid asserts 11 cycles after the 4th accept.
- Readings 0,30,0,50 -> avg_data=40 (zeros excluded, nz_cnt=2).
- Readings 0,0,0,0 -> avg_data=0, avg_valid 2 cycles after the last accept.
- Readings 7,8,0,0:
  - Without ROUND_EN -> avg_data=7.
  - With SENSOR_AVERAGER_ROUND_EN -> avg_data=8.
  - Readings 255,255,255,255 -> 255 in both builds.
- Backpressure: hold avg_ready=0 for 5 cycles -> avg_valid stays 1, avg_data stable, sample_ready=0. The next frame's first reading is accepted only after the handshake.
- Assert rst_n=0 asynchronously after 2 accepted readings:
  - Outputs clear immediately.
  - A fresh frame 100,100,100,100 then yields exactly 100, with no residue from the aborted frame.

Source files
------------

// File: rtl/sensor_averager_pkg.sv
// rtl/sensor_averager_pkg.sv - shared widths and FSM encoding for the sensor averager and its consumers
package sensor_averager_pkg;

    localparam int SENSOR_W        = 8;
    localparam int NUM_SENSORS_DEF = 4;

    typedef enum logic [1:0] {
        COLLECT,
        DIVIDE,
        OUTPUT
    } state_e;

endpackage

// File: rtl/sensor_averager_seq_divider.sv
// rtl/sensor_averager_seq_divider.sv - sequential restoring divider, one quotient bit per cycle MSB first
module seq_divider #(
    parameter int DVD_W = 10,
    parameter int DVS_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o,
    output logic [DVS_W-1:0] remainder_o
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [DVS_W-1:0] src_rem;
    logic [DVD_W-1:0] src_quo;
    logic [DVS_W-1:0] src_dvs;
    logic [DVS_W:0]   shifted;
    logic             ge;

    // The start cycle already performs the first step, so the divide spans DVD_W edges.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_dvs = start_i ? divisor_i : dvs_q;
        shifted = {src_rem, src_quo[DVD_W-1]};
        ge      = shifted >= {1'b0, src_dvs};
        rem_d   = ge ? (shifted[DVS_W-1:0] - src_dvs) : shifted[DVS_W-1:0];
        quo_d   = {src_quo[DVD_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= divisor_i;
                cnt_q  <= CW'(DVD_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/sensor_averager.sv
// rtl/sensor_averager.sv - frame averager of nonzero sensor readings; SENSOR_AVERAGER_ROUND_EN selects round-half-up
module sensor_averager
    import sensor_averager_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SENSOR_W-1:0] sample_data,
    output logic                sample_ready,
    output logic                avg_valid,
    output logic [SENSOR_W-1:0] avg_data,
    input  logic                avg_ready,
    output logic                frame_busy
);

    localparam int SUM_W = SENSOR_W + $clog2(NUM_SENSORS);
    localparam int CNT_W = $clog2(NUM_SENSORS + 1);
    localparam int IDX_W = $clog2(NUM_SENSORS);
`ifdef SENSOR_AVERAGER_ROUND_EN
    localparam int DIV_W = SUM_W + 1;
`else
    localparam int DIV_W = SUM_W;
`endif

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]    nz_cnt_q, nz_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SENSOR_W-1:0] avg_q, avg_d;
    logic                launched_q, launched_d;

    logic                div_start;
    logic                div_done;
    logic [DIV_W-1:0]    dividend;
    logic [DIV_W-1:0]    quotient;
    logic [CNT_W-1:0]    remainder;
    logic                unused_div;

`ifdef SENSOR_AVERAGER_ROUND_EN
    assign dividend = sum_q + DIV_W'(nz_cnt_q >> 1);
`else
    assign dividend = sum_q;
`endif

    // Quotient cannot exceed 255, so its upper bits and the remainder carry no information.
    assign unused_div = ^{quotient[DIV_W-1:SENSOR_W], remainder};

    seq_divider #(
        .DVD_W (DIV_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (div_start),
        .dividend_i  (dividend),
        .divisor_i   (nz_cnt_q),
        .done_o      (div_done),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            sum_q      <= '0;
            nz_cnt_q   <= '0;
            idx_q      <= '0;
            avg_q      <= '0;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            nz_cnt_q   <= nz_cnt_d;
            idx_q      <= idx_d;
            avg_q      <= avg_d;
            launched_q <= launched_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        nz_cnt_d   = nz_cnt_q;
        idx_d      = idx_q;
        avg_d      = avg_q;
        launched_d = launched_q;
        div_start  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (sample_valid) begin
                    if (sample_data != '0) begin
                        sum_d    = sum_q + DIV_W'(sample_data);
                        nz_cnt_d = nz_cnt_q + CNT_W'(1);
                    end
                    if (idx_q == IDX_W'(NUM_SENSORS - 1)) begin
                        idx_d      = '0;
                        launched_d = 1'b0;
                        state_d    = DIVIDE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DIVIDE: begin
                // First cycle launches the divider; an empty frame skips it entirely.
                if (!launched_q) begin
                    launched_d = 1'b1;
                    div_start  = (nz_cnt_q != '0);
                end else if (nz_cnt_q == '0) begin
                    avg_d   = '0;
                    state_d = OUTPUT;
                end else if (div_done) begin
                    avg_d   = quotient[SENSOR_W-1:0];
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (avg_ready) begin
                    sum_d    = '0;
                    nz_cnt_d = '0;
                    idx_d    = '0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign sample_ready = (state_q == COLLECT);
    assign avg_valid    = (state_q == OUTPUT);
    assign avg_data     = avg_q;
    assign frame_busy   = (state_q != COLLECT) || (idx_q != '0);

endmodule

// File: tb/tb_sensor_averager.sv
// tb/tb_sensor_averager.sv - scoreboard bench for sensor_averager
module tb_sensor_averager;

`ifdef SENSOR_AVERAGER_ROUND_EN
    localparam int LAT_NZ = 12;
`else
    localparam int LAT_NZ = 11;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_ready;
    logic       avg_valid;
    logic [7:0] avg_data;
    logic       avg_ready;
    logic       frame_busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];

    sensor_averager dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .avg_valid    (avg_valid),
        .avg_data     (avg_data),
        .avg_ready    (avg_ready),
        .frame_busy   (frame_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_avg(input logic [31:0] f);
        int s = 0;
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (f[8*i +: 8] != 8'd0) begin
                s += int'(f[8*i +: 8]);
                c++;
            end
        end
        if (c == 0) return 8'd0;
`ifdef SENSOR_AVERAGER_ROUND_EN
        s += c / 2;
`endif
        return 8'(s / c);
    endfunction

    function automatic int model_lat(input logic [31:0] f);
        return (f == 32'd0) ? 2 : LAT_NZ;
    endfunction

    task automatic send_reading(input logic [7:0] d);
        int n = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        while (!sample_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sample_ready) check_eq("ready_timeout", 0, 1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        sample_data  = 8'd0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        sb_q.push_back(model_avg(f));
        for (int i = 0; i < 4; i++) send_reading(f[8*i +: 8]);
    endtask

    task automatic get_result(input string tag, input int exp_lat);
        int n = 0;
        logic [7:0] exp;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!avg_valid && n < 200);
        check_eq({tag, "_lat"}, n, exp_lat);
        check_eq({tag, "_valid"}, avg_valid, 1);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
        end else begin
            exp = sb_q.pop_front();
            check_eq({tag, "_data"}, avg_data, exp);
        end
    endtask

    task automatic expect_handshake(input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_hs_valid"}, avg_valid, 0);
        check_eq({tag, "_hs_ready"}, sample_ready, 1);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] f);
        send_frame(f);
        get_result(tag, model_lat(f));
        expect_handshake(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] f;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 8'd0;
        avg_ready    = 1'b1;
        #3;
        check_eq("rst_sample_ready", sample_ready, 1);
        check_eq("rst_avg_valid", avg_valid, 0);
        check_eq("rst_avg_data", avg_data, 0);
        check_eq("rst_frame_busy", frame_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame("f_10_40", {8'd40, 8'd30, 8'd20, 8'd10});
        run_frame("f_nz2", {8'd50, 8'd0, 8'd30, 8'd0});
        run_frame("f_zero", 32'd0);
        run_frame("f_7_8", {8'd0, 8'd0, 8'd8, 8'd7});
        run_frame("f_max", 32'hFFFF_FFFF);

        avg_ready = 1'b0;
        send_frame({8'd40, 8'd30, 8'd20, 8'd10});
        get_result("bp", LAT_NZ);
        sample_valid = 1'b1;
        sample_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_valid", avg_valid, 1);
            check_eq("bp_hold_data", avg_data, 25);
            check_eq("bp_hold_ready", sample_ready, 0);
        end
        avg_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_hs_valid", avg_valid, 0);
        check_eq("bp_hs_ready", sample_ready, 1);
        check_eq("bp_retain_data", avg_data, 25);
        check_eq("bp_idle_busy", frame_busy, 0);
        f = {8'd3, 8'd2, 8'd1, 8'd99};
        sb_q.push_back(model_avg(f));
        send_reading(8'd99);
        check_eq("busy_after_first", frame_busy, 1);
        for (int i = 1; i < 4; i++) send_reading(f[8*i +: 8]);
        get_result("bp_next", LAT_NZ);
        expect_handshake("bp_next");

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++)
                f[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_frame("rand", f);
        end

        send_reading(8'd50);
        send_reading(8'd60);
        check_eq("abort_busy", frame_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_ready", sample_ready, 1);
        check_eq("abort_valid", avg_valid, 0);
        check_eq("abort_data", avg_data, 0);
        check_eq("abort_busy_clr", frame_busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_rst", {8'd100, 8'd100, 8'd100, 8'd100});

        check_eq("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
